// File: rtl/stream_fifo_ovr_pkg.sv
// Shared constants and helpers for the stream FIFO.
// Optional drop counter is enabled by defining STREAM_FIFO_DROP_CNT_EN.
package stream_fifo_pkg;

  localparam int FULL_POLICY_BLOCK     = 0;
  localparam int FULL_POLICY_OVERWRITE = 1;
  localparam int DROP_CNT_W            = 32;

  // Pointer width: one extra MSB over the address so full and empty differ.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ovr_if.sv
// Valid/ready stream interface.
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are
// both 1; tdata is meaningful only while tvalid is 1.
interface stream_fifo_ovr_if #(
  parameter int WIDTH = 512
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/stream_fifo_ovr_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module stream_fifo_ram #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the accepted beat at the write address.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo_ovr.sv
// Single-clock stream FIFO with level, almost flags and selectable full policy
// (back-pressure or overwrite-oldest). Define STREAM_FIFO_DROP_CNT_EN to build
// the saturating drop_count output.
module stream_fifo_ovr
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 512,
  parameter int OVERWRITE = FULL_POLICY_BLOCK,
  parameter int AF_LEVEL  = 56,
  parameter int AE_LEVEL  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  stream_fifo_ovr_if.slave       s_axis,
  stream_fifo_ovr_if.master      m_axis,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow
`ifdef STREAM_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_count
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam bit OVR   = (OVERWRITE == FULL_POLICY_OVERWRITE);
  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_L    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_L    = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             overflow_q, overflow_d;
  logic             rdy_q;
  logic             push, pop, drop, we;

  assign m_axis.tvalid = ~empty_q;

  // rdy_q holds tready low through reset and releases it on the first edge.
  generate
    if (OVR) begin : g_ovr_ready
      assign s_axis.tready = rdy_q;
    end else begin : g_blk_ready
      assign s_axis.tready = rdy_q & ~full_q;
    end
  endgenerate

  // Next pointers, level and flags; a drop advances the read side to discard the oldest.
  always_comb begin
    push       = s_axis.tvalid & s_axis.tready;
    pop        = ~empty_q & m_axis.tready;
    drop       = OVR & push & full_q & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = 1'b0;
    we         = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      we = push;
      if (push)        wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop || drop) rd_ptr_d = rd_ptr_q + 1'b1;
      overflow_d = drop;
    end
    level_d = wr_ptr_d - rd_ptr_d;
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
    af_d    = (level_d >= AF_L);
    ae_d    = (level_d <= AE_L);
  end

  // State registers: pointers, level and flags all move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      overflow_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      overflow_q <= overflow_d;
      rdy_q      <= 1'b1;
    end
  end

  stream_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (s_axis.tdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (m_axis.tdata)
  );

  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = overflow_q;

`ifdef STREAM_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Saturating count of dropped entries; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (overflow_d && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_fifo_ovr.sv
// Bench for stream_fifo_ovr: one back-pressure instance and one overwrite
// instance, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2. Honors STREAM_FIFO_DROP_CNT_EN.
module tb_stream_fifo_ovr;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] level0, level1;
  logic       full0, empty0, af0, ae0, ovf0;
  logic       full1, empty1, af1, ae1, ovf1;
`ifdef STREAM_FIFO_DROP_CNT_EN
  logic [31:0] drop0, drop1;
`endif

  int checks   = 0;
  int failures = 0;

  stream_fifo_ovr_if #(.WIDTH(W)) s0 ();
  stream_fifo_ovr_if #(.WIDTH(W)) m0 ();
  stream_fifo_ovr_if #(.WIDTH(W)) s1 ();
  stream_fifo_ovr_if #(.WIDTH(W)) m1 ();

  // clock / reset block
  always #5 clk = ~clk;

  stream_fifo_ovr #(.DEPTH(8), .WIDTH(W), .OVERWRITE(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_blk (
    .clk (clk), .rst_n (rst_n), .flush (flush), .s_axis (s0), .m_axis (m0),
    .level (level0), .full (full0), .empty (empty0), .almost_full (af0),
    .almost_empty (ae0), .overflow (ovf0)
`ifdef STREAM_FIFO_DROP_CNT_EN
    , .drop_count (drop0)
`endif
  );

  stream_fifo_ovr #(.DEPTH(8), .WIDTH(W), .OVERWRITE(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_ovr (
    .clk (clk), .rst_n (rst_n), .flush (flush), .s_axis (s1), .m_axis (m1),
    .level (level1), .full (full1), .empty (empty1), .almost_full (af1),
    .almost_empty (ae1), .overflow (ovf1)
`ifdef STREAM_FIFO_DROP_CNT_EN
    , .drop_count (drop1)
`endif
  );

  // driver tasks: apply inputs one cycle, return at posedge+1
  task automatic step0(input logic v, input logic [W-1:0] d, input logic r);
    s0.tvalid = v; s0.tdata = d; m0.tready = r;
    @(posedge clk); #1;
    s0.tvalid = 1'b0; m0.tready = 1'b0;
  endtask

  task automatic step1(input logic v, input logic [W-1:0] d, input logic r);
    s1.tvalid = v; s1.tdata = d; m1.tready = r;
    @(posedge clk); #1;
    s1.tvalid = 1'b0; m1.tready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    s0.tvalid = 1'b0; s0.tdata = '0; m0.tready = 1'b0;
    s1.tvalid = 1'b0; s1.tdata = '0; m1.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s0.tready !== 1'b0) begin failures++; $display("FAIL rst_tready0: got %b exp 0", s0.tready); end
    checks++; if (s1.tready !== 1'b0) begin failures++; $display("FAIL rst_tready1: got %b exp 0", s1.tready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (level0 !== 4'd0) begin failures++; $display("FAIL rst_level0: got %0d exp 0", level0); end
    checks++; if ({full0, empty0, af0, ae0, m0.tvalid, ovf0} !== 6'b010100) begin
      failures++; $display("FAIL rst_flags0: got %b exp 010100", {full0, empty0, af0, ae0, m0.tvalid, ovf0}); end
    checks++; if ({full1, empty1, af1, ae1, m1.tvalid, ovf1} !== 6'b010100) begin
      failures++; $display("FAIL rst_flags1: got %b exp 010100", {full1, empty1, af1, ae1, m1.tvalid, ovf1}); end
    checks++; if (s0.tready !== 1'b1) begin failures++; $display("FAIL post_rst_tready0: got %b exp 1", s0.tready); end
    checks++; if (s1.tready !== 1'b1) begin failures++; $display("FAIL post_rst_tready1: got %b exp 1", s1.tready); end
`ifdef STREAM_FIFO_DROP_CNT_EN
    checks++; if (drop1 !== 32'd0) begin failures++; $display("FAIL rst_drop1: got %0d exp 0", drop1); end
`endif
  endtask

  // Fill 1..8 with flag tracking, rejected push when full, then drain in order.
  task automatic test_fill_block();
    logic exp_ae [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_af [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 1; i <= 8; i++) begin
      step0(1'b1, W'(i), 1'b0);
      checks++; if (level0 !== 4'(i)) begin failures++; $display("FAIL fill_level: got %0d exp %0d", level0, i); end
      checks++; if ({ae0, af0} !== {exp_ae[i], exp_af[i]}) begin
        failures++; $display("FAIL fill_ae_af at %0d: got %b exp %b", i, {ae0, af0}, {exp_ae[i], exp_af[i]}); end
      checks++; if (m0.tvalid !== 1'b1 || m0.tdata !== 16'd1) begin
        failures++; $display("FAIL fill_head: got v=%b d=%0h exp v=1 d=1", m0.tvalid, m0.tdata); end
    end
    checks++; if ({full0, s0.tready} !== 2'b10) begin
      failures++; $display("FAIL full_block: got full/tready=%b exp 10", {full0, s0.tready}); end
    step0(1'b1, 16'h0099, 1'b1);
    checks++; if (level0 !== 4'd7 || full0 !== 1'b0) begin
      failures++; $display("FAIL full_pushpop_block: got level=%0d full=%b exp 7 0", level0, full0); end
    for (int i = 2; i <= 8; i++) begin
      checks++; if (m0.tvalid !== 1'b1 || m0.tdata !== W'(i)) begin
        failures++; $display("FAIL drain_data: got v=%b d=%0h exp d=%0h", m0.tvalid, m0.tdata, i); end
      step0(1'b0, '0, 1'b1);
    end
    checks++; if ({empty0, m0.tvalid, level0} !== {2'b10, 4'd0}) begin
      failures++; $display("FAIL drain_empty: got empty=%b v=%b level=%0d", empty0, m0.tvalid, level0); end
  endtask

  // Overwrite: 10 pushes into 8 slots drop the two oldest.
  task automatic test_overwrite();
    for (int i = 1; i <= 10; i++) begin
      step1(1'b1, W'(i), 1'b0);
      checks++; if (ovf1 !== (i >= 9)) begin
        failures++; $display("FAIL ovr_pulse at %0d: got %b exp %b", i, ovf1, (i >= 9)); end
    end
    checks++; if (level1 !== 4'd8 || full1 !== 1'b1) begin
      failures++; $display("FAIL ovr_level: got %0d full=%b exp 8 1", level1, full1); end
`ifdef STREAM_FIFO_DROP_CNT_EN
    checks++; if (drop1 !== 32'd2) begin failures++; $display("FAIL ovr_drop_cnt: got %0d exp 2", drop1); end
`endif
    step1(1'b0, '0, 1'b0);
    checks++; if (ovf1 !== 1'b0) begin failures++; $display("FAIL ovr_pulse_end: got %b exp 0", ovf1); end
    for (int i = 3; i <= 10; i++) begin
      checks++; if (m1.tvalid !== 1'b1 || m1.tdata !== W'(i)) begin
        failures++; $display("FAIL ovr_drain: got v=%b d=%0h exp d=%0h", m1.tvalid, m1.tdata, i); end
      step1(1'b0, '0, 1'b1);
    end
    checks++; if (empty1 !== 1'b1) begin failures++; $display("FAIL ovr_empty: got %b exp 1", empty1); end
  endtask

  // Overwrite instance full, push and pop together: no drop.
  task automatic test_ovr_push_pop();
    for (int i = 0; i < 8; i++) step1(1'b1, W'(20 + i), 1'b0);
    checks++; if (full1 !== 1'b1 || m1.tdata !== 16'd20) begin
      failures++; $display("FAIL ovr_pp_pre: got full=%b d=%0h exp 1 14", full1, m1.tdata); end
    step1(1'b1, 16'd28, 1'b1);
    checks++; if (ovf1 !== 1'b0 || level1 !== 4'd8) begin
      failures++; $display("FAIL ovr_pp: got ovf=%b level=%0d exp 0 8", ovf1, level1); end
    for (int i = 21; i <= 28; i++) begin
      checks++; if (m1.tdata !== W'(i)) begin
        failures++; $display("FAIL ovr_pp_drain: got %0h exp %0h", m1.tdata, i); end
      step1(1'b0, '0, 1'b1);
    end
    checks++; if (empty1 !== 1'b1) begin failures++; $display("FAIL ovr_pp_empty: got %b exp 1", empty1); end
  endtask

  // Streaming at level 4 for 3*DEPTH cycles, wrapping pointers three times.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step0(1'b1, W'(100 + i), 1'b0);
    for (int i = 0; i < 24; i++) begin
      checks++; if (m0.tdata !== W'(100 + i)) begin
        failures++; $display("FAIL b2b_data: got %0h exp %0h", m0.tdata, 100 + i); end
      step0(1'b1, W'(104 + i), 1'b1);
      checks++; if ({level0, full0, empty0, ae0, af0} !== {4'd4, 4'b0000}) begin
        failures++; $display("FAIL b2b_flags: got %b exp 01000000", {level0, full0, empty0, ae0, af0}); end
    end
    for (int i = 124; i < 128; i++) begin
      checks++; if (m0.tdata !== W'(i)) begin
        failures++; $display("FAIL b2b_drain: got %0h exp %0h", m0.tdata, i); end
      step0(1'b0, '0, 1'b1);
    end
    checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL b2b_empty: got %b exp 1", empty0); end
  endtask

  // Flush at level 5 with a coincident push, then asynchronous reset at level 5.
  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) step1(1'b1, W'(40 + i), 1'b0);
    checks++; if (level1 !== 4'd5) begin failures++; $display("FAIL fl_pre_level: got %0d exp 5", level1); end
    flush = 1'b1;
    step1(1'b1, 16'h0077, 1'b1);
    flush = 1'b0;
    checks++; if ({level1, empty1, m1.tvalid, ovf1} !== {4'd0, 3'b100}) begin
      failures++; $display("FAIL flush_state: got level=%0d empty=%b v=%b ovf=%b", level1, empty1, m1.tvalid, ovf1); end
`ifdef STREAM_FIFO_DROP_CNT_EN
    checks++; if (drop1 !== 32'd2) begin failures++; $display("FAIL flush_drop_cnt: got %0d exp 2", drop1); end
`endif
    for (int i = 0; i < 5; i++) step1(1'b1, W'(50 + i), 1'b0);
    checks++; if (level1 !== 4'd5 || m1.tdata !== 16'd50) begin
      failures++; $display("FAIL post_flush: got level=%0d d=%0h exp 5 32", level1, m1.tdata); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({level1, empty1, m1.tvalid, s1.tready} !== {4'd0, 3'b100}) begin
      failures++; $display("FAIL async_rst: got level=%0d empty=%b v=%b rdy=%b", level1, empty1, m1.tvalid, s1.tready); end
`ifdef STREAM_FIFO_DROP_CNT_EN
    checks++; if (drop1 !== 32'd0) begin failures++; $display("FAIL rst_drop_clear: got %0d exp 0", drop1); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s1.tready !== 1'b1 || empty1 !== 1'b1) begin
      failures++; $display("FAIL rst_release: got rdy=%b empty=%b exp 1 1", s1.tready, empty1); end
  endtask

  initial begin
    test_reset();
    test_fill_block();
    test_overwrite();
    test_ovr_push_pop();
    test_back_to_back();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
